// File: rtl/spio_hss_multiplexer_frame_assembler.sv
// spio_hss_multiplexer_frame_assembler: packs channel packets into numbered, coloured frames under a sliding credit window
module spio_hss_multiplexer_frame_assembler #(
    parameter int NUM_CHANS = 8,
    parameter int PKT_BITS  = 64,
    parameter int SEQ_BITS  = 7,
    parameter int WIN       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CHANS*PKT_BITS-1:0] pkt_data,
    input  logic [NUM_CHANS-1:0]          pkt_vld,
    output logic [NUM_CHANS-1:0]          pkt_rdy,
    output logic [31:0]                   frm_data,
    output logic [3:0]                    frm_kchr,
    output logic                          frm_last,
    output logic                          frm_vld,
    input  logic                          frm_rdy,
    input  logic                          ack_vld,
    input  logic [SEQ_BITS-1:0]           ack_seq,
    input  logic                          ack_colour,
    input  logic                          nak_vld,
    input  logic [SEQ_BITS-1:0]           nak_seq,
    output logic                          ooc_colour,
    output logic                          ooc_vld,
    output logic [SEQ_BITS-1:0]           reg_outs
);
    localparam int WPP = PKT_BITS / 32;
    localparam int CW  = NUM_CHANS > 1 ? $clog2(NUM_CHANS) : 1;
    localparam int WW  = WPP > 1 ? $clog2(WPP) : 1;

    typedef enum logic [1:0] {IDLE, HDR, PLD, CRC} state_t;

    state_t                        state;
    logic [SEQ_BITS-1:0]           seq, ack_ptr, outs, ack_dist;
    logic                          colour, nak_sup, ooc_armed;
    logic                          credit_ok, accept, adv, crc_done;
    logic [NUM_CHANS-1:0]          mask;
    logic [NUM_CHANS*PKT_BITS-1:0] pkt_buf;
    logic [CW-1:0]                 ch, nxt_ch, sel_ch;
    logic [WW-1:0]                 wd, sel_wd;
    logic                          has_nxt, step_wd, to_crc;
    logic [31:0]                   nxt_word;

    assign outs       = seq - ack_ptr;
    assign ack_dist   = ack_seq - ack_ptr;
    assign credit_ok  = outs < SEQ_BITS'(WIN);
    assign pkt_rdy    = (!rst && state == IDLE && credit_ok) ? pkt_vld : '0;
    assign accept     = |pkt_rdy;
    assign ooc_vld    = !rst && state == IDLE && |pkt_vld && !credit_ok && ooc_armed;
    assign ooc_colour = colour;
    assign adv        = frm_vld && frm_rdy;
    assign crc_done   = state == CRC && adv;

    // lowest selected channel above the current one (any selected channel when leaving the header)
    always_comb begin
        nxt_ch  = '0;
        has_nxt = 1'b0;
        for (int c = NUM_CHANS - 1; c >= 0; c--)
            if (mask[c] && (state == HDR || c > int'(ch))) begin
                nxt_ch  = CW'(c);
                has_nxt = 1'b1;
            end
    end

    always_comb begin
        step_wd  = state == PLD && wd != WW'(WPP - 1);
        sel_ch   = step_wd ? ch : nxt_ch;
        sel_wd   = step_wd ? wd + 1'b1 : '0;
        to_crc   = state == PLD && !step_wd && !has_nxt;
        nxt_word = pkt_buf[int'(sel_ch)*PKT_BITS + (WPP - 1 - int'(sel_wd))*32 +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            seq       <= '0;
            ack_ptr   <= '0;
            colour    <= 1'b0;
            nak_sup   <= 1'b0;
            ooc_armed <= 1'b1;
            reg_outs  <= '0;
            frm_vld   <= 1'b0;
            frm_data  <= '0;
            frm_kchr  <= '0;
            frm_last  <= 1'b0;
            mask      <= '0;
            ch        <= '0;
            wd        <= '0;
        end else begin
            reg_outs <= outs;
            if (ooc_vld) ooc_armed <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    mask      <= pkt_vld;
                    pkt_buf   <= pkt_data;
                    frm_vld   <= 1'b1;
                    frm_data  <= {8'({colour, seq}), 8'h00, 8'(pkt_vld), 8'hBC};
                    frm_kchr  <= 4'b0001;
                    ooc_armed <= 1'b1;
                    state     <= HDR;
                end
                HDR, PLD: if (adv) begin
                    ch       <= sel_ch;
                    wd       <= sel_wd;
                    frm_data <= to_crc ? '0 : nxt_word;
                    frm_kchr <= '0;
                    frm_last <= to_crc;
                    state    <= to_crc ? CRC : PLD;
                end
                CRC: if (adv) begin
                    frm_vld  <= 1'b0;
                    frm_last <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // a nak mid-frame lets the frame finish but must not bump the resumed sequence
            if (nak_vld) begin
                colour  <= ~colour;
                seq     <= nak_seq;
                ack_ptr <= nak_seq;
            end else begin
                if (crc_done && !nak_sup) seq <= seq + 1'b1;
                if (ack_vld && ack_colour == colour && ack_dist <= outs) ack_ptr <= ack_seq;
            end
            nak_sup <= crc_done ? 1'b0 : (nak_vld && (state != IDLE || accept)) ? 1'b1 : nak_sup;
        end
    end
endmodule

// File: tb/tb_spio_hss_multiplexer_frame_assembler.sv
// tb_spio_hss_multiplexer_frame_assembler: directed frames checked word by word through a scoreboard queue
module tb_spio_hss_multiplexer_frame_assembler;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*64-1:0] pkt_data;
    logic [N-1:0]   pkt_vld, pkt_rdy;
    logic [31:0]    frm_data;
    logic [3:0]     frm_kchr;
    logic           frm_last, frm_vld, frm_rdy;
    logic           ack_vld, ack_colour, nak_vld;
    logic [6:0]     ack_seq, nak_seq, reg_outs;
    logic           ooc_colour, ooc_vld;

    int total = 0;
    int bad = 0;
    int ooc_cnt = 0;
    logic [36:0] sb[$];
    logic [6:0]  exp_seq = 7'd0;
    logic        exp_col = 1'b0;

    spio_hss_multiplexer_frame_assembler #(
        .NUM_CHANS(N), .PKT_BITS(64), .SEQ_BITS(7), .WIN(8)
    ) dut (
        .clk(clk), .rst(rst), .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
        .frm_data(frm_data), .frm_kchr(frm_kchr), .frm_last(frm_last), .frm_vld(frm_vld),
        .frm_rdy(frm_rdy), .ack_vld(ack_vld), .ack_seq(ack_seq), .ack_colour(ack_colour),
        .nak_vld(nak_vld), .nak_seq(nak_seq), .ooc_colour(ooc_colour), .ooc_vld(ooc_vld),
        .reg_outs(reg_outs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ooc_vld) ooc_cnt++;
        if (frm_vld && frm_rdy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h want none", {frm_last, frm_kchr, frm_data});
            end else begin
                chk("frame_word", {27'd0, frm_last, frm_kchr, frm_data}, {27'd0, sb.pop_front()});
            end
        end
    end

    task automatic push_frame(input logic [7:0] msk);
        sb.push_back({1'b0, 4'b0001, exp_col, exp_seq, 8'h00, msk, 8'hBC});
        for (int c = 0; c < N; c++)
            if (msk[c]) begin
                sb.push_back({1'b0, 4'h0, pkt_data[c*64+32 +: 32]});
                sb.push_back({1'b0, 4'h0, pkt_data[c*64 +: 32]});
            end
        sb.push_back({1'b1, 4'h0, 32'h0});
    endtask

    task automatic send(input logic [7:0] msk);
        int n = 0;
        pkt_vld = msk;
        do begin
            @(negedge clk);
            n++;
        end while (pkt_rdy !== msk && n < 200);
        chk("accept", {56'd0, pkt_rdy}, {56'd0, msk});
        if (pkt_rdy === msk) begin
            push_frame(msk);
            exp_seq = exp_seq + 7'd1;
            @(posedge clk);
            #1 pkt_vld = '0;
            chk("hdr_latency", {63'd0, frm_vld}, 64'd1);
        end else begin
            pkt_vld = '0;
        end
    endtask

    task automatic drain;
        int n = 0;
        while ((sb.size() != 0 || frm_vld) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic ack(input logic [6:0] s, input logic c);
        ack_vld = 1'b1; ack_seq = s; ack_colour = c;
        @(posedge clk);
        #1 ack_vld = 1'b0;
    endtask

    task automatic nak(input logic [6:0] s);
        nak_vld = 1'b1; nak_seq = s;
        @(posedge clk);
        #1 nak_vld = 1'b0;
        exp_seq = s;
        exp_col = ~exp_col;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_frm_vld"}, {63'd0, frm_vld}, 64'd0);
        chk({tag, "_frm_data"}, {32'd0, frm_data}, 64'd0);
        chk({tag, "_frm_kchr"}, {60'd0, frm_kchr}, 64'd0);
        chk({tag, "_frm_last"}, {63'd0, frm_last}, 64'd0);
        chk({tag, "_ooc_vld"}, {63'd0, ooc_vld}, 64'd0);
        chk({tag, "_reg_outs"}, {57'd0, reg_outs}, 64'd0);
        chk({tag, "_pkt_rdy"}, {56'd0, pkt_rdy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pkt_vld = 8'hFF; frm_rdy = 1'b1;
        ack_vld = 1'b0; ack_seq = '0; ack_colour = 1'b0; nak_vld = 1'b0; nak_seq = '0;
        for (int c = 0; c < N; c++)
            pkt_data[c*64 +: 64] = {32'hC0DE_0000 + 32'(c), 32'hBEEF_0000 + 32'(c)};
        pkt_data[2*64 +: 64] = 64'h0123_4567_89AB_CDEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_ooc_colour", {63'd0, ooc_colour}, 64'd0);
        pkt_vld = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // single channel 2: header 0000_04BC
        send(8'h04);
        drain();
        chk("outs_after_one", {57'd0, reg_outs}, 64'd1);

        // channels 0, 5, 7: header 0100_A1BC, payload in ascending channel order
        send(8'hA1);
        drain();

        // backpressure on first payload word of channel 1
        send(8'h02);
        @(posedge clk);
        #1 frm_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_data", {32'd0, frm_data}, {32'd0, 32'hC0DE_0001});
            chk("stall_vld", {63'd0, frm_vld}, 64'd1);
            @(posedge clk);
        end
        #1 frm_rdy = 1'b1;
        drain();

        // credit: clear window, fill 8 frames, then out of credit
        ack(7'd3, 1'b0);
        cycles(2);
        chk("outs_cleared", {57'd0, reg_outs}, 64'd0);
        for (int i = 0; i < 8; i++) send(8'h01);
        ooc_cnt = 0;
        pkt_vld = 8'h01;
        cycles(12);
        chk("ooc_once", 64'(ooc_cnt), 64'd1);
        chk("ooc_colour", {63'd0, ooc_colour}, 64'd0);
        chk("ooc_pkt_rdy", {56'd0, pkt_rdy}, 64'd0);
        chk("outs_full", {57'd0, reg_outs}, 64'd8);
        chk("sb_after_fill", 64'(sb.size()), 64'd0);
        ack(7'd6, 1'b1);
        cycles(2);
        chk("wrong_colour_outs", {57'd0, reg_outs}, 64'd8);
        chk("wrong_colour_rdy", {56'd0, pkt_rdy}, 64'd0);
        pkt_vld = '0;
        ack(7'd6, 1'b0);
        cycles(2);
        chk("outs_after_ack", {57'd0, reg_outs}, 64'd5);
        send(8'h01);
        drain();

        // nak mid-payload: frame seq 12 completes, next header colour 1 seq 2
        send(8'h10);
        @(posedge clk);
        #1 nak(7'd2);
        drain();
        send(8'h40);
        drain();
        chk("outs_after_nak", {57'd0, reg_outs}, 64'd1);

        // sequence wrap 126 -> 127 -> 0 with an ack across it
        nak(7'd126);
        cycles(1);
        send(8'h08);
        drain();
        ack(7'd127, 1'b0);
        send(8'h08);
        drain();
        send(8'h80);
        drain();
        chk("outs_wrap", {57'd0, reg_outs}, 64'd2);

        // reset mid-payload abandons the frame; next header restarts at seq 0
        send(8'h08);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("midreset");
        chk("abandoned_words", 64'(sb.size()), 64'd2);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        exp_seq = 7'd0;
        exp_col = 1'b0;
        send(8'h08);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
